// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, line levels and parity helper for the UART TX path.
// Contents: state_e (IDLE, START, DATA, PARITY, STOP), LINE_IDLE/START_BIT/STOP_BIT levels,
//           MAX_DW (widest supported data word), par_calc(data, par_type).
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   MAX_DW    = 9;
   // Data is zero-extended to MAX_DW; extra zeros leave the XOR unchanged.
   // par_type=0 gives even (XOR), par_type=1 gives odd (XNOR).
   function automatic logic par_calc(input logic [MAX_DW-1:0] data, input logic par_type);
      return (^data) ^ par_type;
   endfunction
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, pulses bit_tick_o on the last cycle of each serial bit.
// Ports: clk, rst (sync active-high), en_i (0 clears the count), bit_tick_o.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic bit_tick_o
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   logic [CW-1:0] cnt_q, cnt_d;
   assign bit_tick_o = en_i && (cnt_q == CW'(CLKS_PER_BIT - 1));
   always_comb cnt_d = (!en_i || bit_tick_o) ? '0 : cnt_q + 1'b1;
   always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer (start, data LSB first, optional parity, stop).
// Ports: clk, rst (sync active-high); tx_valid_i/tx_data_i/tx_ready_o accept handshake;
//        par_en_i, par_type_i (0 even, 1 odd) parity control; tx_out_o serial line (idle high);
//        busy_o frame in progress. tx_out_o and busy_o are registered.
// Option: define UART_TX_TWO_STOP_EN for two stop bits.
module uart_tx_ctrl
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid_i,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  par_en_i,
   input  logic                  par_type_i,
   output logic                  tx_ready_o,
   output logic                  tx_out_o,
   output logic                  busy_o
);
   localparam int IW = $clog2(DATA_WIDTH);
   state_e                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d, par_bit_q, par_bit_d;
   logic                  tx_out_d, bit_tick, accept;
`ifdef UART_TX_TWO_STOP_EN
   logic                  stop2_q, stop2_d;
`endif
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk        (clk),
      .rst        (rst),
      .en_i       (state_q != IDLE),
      .bit_tick_o (bit_tick)
   );
   assign tx_ready_o = (state_q == IDLE) && !rst;
   assign accept     = tx_valid_i && tx_ready_o;
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      data_d    = data_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
`ifdef UART_TX_TWO_STOP_EN
      stop2_d   = stop2_q;
`endif
      case (state_q)
         IDLE: if (accept) begin
            data_d    = tx_data_i;
            par_en_d  = par_en_i;
            par_bit_d = par_calc(MAX_DW'(tx_data_i), par_type_i);
            state_d   = START;
         end
         START: if (bit_tick) begin
            state_d = DATA;
            idx_d   = '0;
         end
         DATA: if (bit_tick) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(DATA_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
         end
         PARITY: if (bit_tick) state_d = STOP;
         STOP: if (bit_tick) begin
`ifdef UART_TX_TWO_STOP_EN
            // First tick finishes stop bit one; the second ends the frame.
            stop2_d = !stop2_q;
            if (stop2_q) state_d = IDLE;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
      // Line level follows the next state so it lines up with the registered state.
      tx_out_d = (state_d == START)  ? START_BIT :
                 (state_d == DATA)   ? data_d[idx_d] :
                 (state_d == PARITY) ? par_bit_d :
                 (state_d == STOP)   ? STOP_BIT : LINE_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_out_o  <= LINE_IDLE;
         busy_o    <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
         stop2_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         tx_out_o  <= tx_out_d;
         busy_o    <= (state_d != IDLE);
`ifdef UART_TX_TWO_STOP_EN
         stop2_q   <= stop2_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: directed table-driven bench for uart_tx_ctrl (DATA_WIDTH=8, CLKS_PER_BIT=4).
module tb_uart_tx_ctrl;
   localparam int CPB = 4;
`ifdef UART_TX_TWO_STOP_EN
   localparam int NSTOP = 2;
`else
   localparam int NSTOP = 1;
`endif
   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic       par;
      logic       poke;
   } vec_t;
   logic       clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, par_en = 1'b0, par_type = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, tx_out, busy;
   int         n_cmp = 0, n_fail = 0;
   vec_t       v[7];
   always #5 clk = ~clk;
   uart_tx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_valid_i (tx_valid),
      .tx_data_i  (tx_data),
      .par_en_i   (par_en),
      .par_type_i (par_type),
      .tx_ready_o (tx_ready),
      .tx_out_o   (tx_out),
      .busy_o     (busy)
   );
   task automatic chk(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
      end
   endtask
   function automatic logic exp_bit(input logic [7:0] d, input logic pe, input logic par, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == 9 && pe) return par;
      return 1'b1;
   endfunction
   task automatic wait_ready();
      int i = 0;
      @(negedge clk);
      while (!tx_ready && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk("ready_wait", tx_ready, 1'b1);
   endtask
   task automatic check_frame(input logic [7:0] d, input logic pe, input logic par, input logic poke);
      int nb = 9 + int'(pe) + NSTOP;
      for (int c = 0; c < nb * CPB; c++) begin
         @(negedge clk);
         chk($sformatf("line_bit%0d_cyc%0d", c / CPB, c), tx_out, exp_bit(d, pe, par, c / CPB));
         chk($sformatf("busy_cyc%0d", c), busy, 1'b1);
         chk($sformatf("ready_low_cyc%0d", c), tx_ready, 1'b0);
         if (poke) begin
            tx_valid = (c >= 10 && c < 14);
            tx_data  = 8'h00;
         end
      end
   endtask
   task automatic idle_chk(input string nm);
      @(negedge clk);
      chk({nm, "_tx_out"}, tx_out, 1'b1);
      chk({nm, "_busy"}, busy, 1'b0);
      chk({nm, "_ready"}, tx_ready, 1'b1);
   endtask
   task automatic send(input vec_t x);
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = x.d;
      par_en   = x.pe;
      par_type = x.pt;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = ~x.d;
      par_en   = ~x.pe;
      par_type = ~x.pt;
      check_frame(x.d, x.pe, x.par, x.poke);
      idle_chk("post_frame");
      if (x.poke) repeat (3) idle_chk("poke_ignored");
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
   initial begin
      v[0] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, par: 1'b0, poke: 1'b0};
      v[1] = '{d: 8'hA5, pe: 1'b1, pt: 1'b1, par: 1'b1, poke: 1'b0};
      v[2] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, par: 1'b0, poke: 1'b1};
      v[3] = '{d: 8'h01, pe: 1'b1, pt: 1'b0, par: 1'b1, poke: 1'b0};
      v[4] = '{d: 8'hFF, pe: 1'b1, pt: 1'b1, par: 1'b1, poke: 1'b0};
      v[5] = '{d: 8'h3C, pe: 1'b1, pt: 1'b0, par: 1'b0, poke: 1'b1};
      v[6] = '{d: 8'h80, pe: 1'b1, pt: 1'b1, par: 1'b0, poke: 1'b0};
      repeat (2) begin
         @(negedge clk);
         chk("rst_tx_out", tx_out, 1'b1);
         chk("rst_busy", busy, 1'b0);
         chk("rst_ready", tx_ready, 1'b0);
      end
      rst = 1'b0;
      idle_chk("after_rst");
      for (int i = 0; i < 7; i++) send(v[i]);
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = 8'h01;
      par_en   = 1'b0;
      par_type = 1'b0;
      @(posedge clk);
      #1;
      tx_data = 8'hFF;
      check_frame(8'h01, 1'b0, 1'b0, 1'b0);
      idle_chk("b2b_gap");
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      check_frame(8'hFF, 1'b0, 1'b0, 1'b0);
      idle_chk("b2b_end");
      wait_ready();
      tx_valid = 1'b1;
      tx_data  = 8'h3C;
      par_en   = 1'b0;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      repeat (17) @(negedge clk);
      chk("mid_data_bit3", tx_out, 1'b1);
      chk("mid_busy", busy, 1'b1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ready", tx_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_chk("abort");
      send('{d: 8'h3C, pe: 1'b0, pt: 1'b0, par: 1'b0, poke: 1'b0});
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
